// File: rtl/mul3_pkg.sv
// mul3_pkg
// Shared definitions for the shared-multiplier arbiter slice.
//   OPW     : operand width of the multiplier (3 bits)
//   PW      : product width (6 bits, holds 7*7 exactly)
//   state_t : controller states IDLE -> CALC -> DONE -> IDLE
package mul3_pkg;

    localparam int OPW = 3;
    localparam int PW  = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul3x3_core.sv
// mul3x3_core
// Purely combinational 3x3 unsigned array multiplier.
// Ports:
//   a, b : OPW-bit unsigned operands
//   p    : PW-bit exact product a*b
module mul3x3_core
    import mul3_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [PW-1:0]  p
);

    logic [PW-1:0] pp0;
    logic [PW-1:0] pp1;
    logic [PW-1:0] pp2;

    // One AND row per bit of b, shifted into place, then summed.
    always_comb begin
        pp0 = {3'b000, a & {OPW{b[0]}}};
        pp1 = {2'b00, a & {OPW{b[1]}}, 1'b0};
        pp2 = {1'b0, a & {OPW{b[2]}}, 2'b00};
        p   = pp0 + pp1 + pp2;
    end

endmodule

// File: rtl/mul3_arbiter.sv
// mul3_arbiter
// Shares one 3x3 multiplier among NREQ requesters through a round-robin
// arbiter. Operands are registered on grant, the product one cycle later,
// and the result is offered over a valid/ready handshake.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (req_ready one-hot)
//   req_a, req_b          : packed operands, requester i in [3i+2:3i]
//   res_valid/res_ready   : result handshake
//   res_p, res_id         : product and owning requester index
//   busy                  : high while in CALC or DONE
//   op_count              : completed result handshakes, wraps at 256
module mul3_arbiter
    import mul3_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                res_valid,
    output logic [PW-1:0]       res_p,
    output logic [IDW-1:0]      res_id,
    input  logic                res_ready,
    output logic                busy,
    output logic [7:0]          op_count
);

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] rr_ptr;
    logic [OPW-1:0] op_a;
    logic [OPW-1:0] op_b;
    logic [IDW-1:0] op_id;
    logic [PW-1:0]  core_p;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  hi_id;
    logic [IDW-1:0]  lo_id;
    logic            hi_found;
    logic [OPW-1:0]  sel_a;
    logic [OPW-1:0]  sel_b;
    logic            handshake;

    // Round-robin pick: the lowest valid index at or above rr_ptr wins;
    // if none exists, the search wraps and the lowest valid index wins.
    // Scanning downward makes the last hit the smallest index.
    always_comb begin
        hi_id    = '0;
        lo_id    = '0;
        hi_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_id = IDW'(i);
                if (i >= int'(rr_ptr)) begin
                    hi_found = 1'b1;
                    hi_id    = IDW'(i);
                end
            end
        end
        grant_id = hi_found ? hi_id : lo_id;
        grant    = (|req_valid) ? (NREQ'(1) << grant_id) : '0;
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_id) begin
                sel_a = req_a[i*OPW +: OPW];
                sel_b = req_b[i*OPW +: OPW];
            end
        end
    end

    // Grants are offered only in IDLE; the reset cycle is masked so a
    // request present while rst is high is never accepted.
    assign req_ready = (state == S_IDLE && !rst) ? grant : '0;
    assign handshake = |(req_valid & req_ready);

    // The single shared multiplier always looks at the latched operands.
    mul3x3_core u_core (
        .a (op_a),
        .b (op_b),
        .p (core_p)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Controller next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (handshake) state_next = S_CALC;
            S_CALC: state_next = S_DONE;
            S_DONE: if (res_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath registers: operand capture on grant, product capture in
    // CALC, and the completion counter on the result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_id    <= '0;
            res_p    <= '0;
            res_id   <= '0;
            op_count <= '0;
        end else begin
            if (state == S_IDLE && handshake) begin
                op_a   <= sel_a;
                op_b   <= sel_b;
                op_id  <= grant_id;
                rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            end
            if (state == S_CALC) begin
                res_p  <= core_p;
                res_id <= op_id;
            end
            if (state == S_DONE && res_ready) begin
                op_count <= op_count + 8'd1;
            end
        end
    end

    assign res_valid = (state == S_DONE);
    assign busy      = (state == S_CALC) || (state == S_DONE);

endmodule

// File: tb/tb_mul3_arbiter.sv
// tb_mul3_arbiter
// Directed self-checking bench for mul3_arbiter (NREQ=4, IDW=2).
module tb_mul3_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [11:0] req_a;
    logic [11:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [5:0]  res_p;
    logic [1:0]  res_id;
    logic        res_ready;
    logic        busy;
    logic [7:0]  op_count;

    int checks;
    int errors;
    int rr_prod [4];

    mul3_arbiter #(
        .NREQ (4),
        .IDW  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_p     (res_p),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the design never returns to IDLE.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d required %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic rdy);
        req_valid = valid;
        res_ready = rdy;
        #1;
    endtask

    task automatic setOperands(input int id, input logic [2:0] a, input logic [2:0] b);
        req_a[id*3 +: 3] = a;
        req_b[id*3 +: 3] = b;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One full transaction from IDLE with the consumer always ready.
    task automatic runOp(input logic [3:0] valid, input int expGrant,
                         input int expProd, input string tag);
        applyStimulus(valid, 1'b1);
        checkOutput({tag, "_grant"}, req_ready, 32'(1 << expGrant));
        tick();
        checkOutput({tag, "_busy"}, busy, 1);
        checkOutput({tag, "_calc_ready"}, req_ready, 0);
        tick();
        checkOutput({tag, "_valid"}, res_valid, 1);
        checkOutput({tag, "_prod"}, res_p, expProd);
        checkOutput({tag, "_id"}, res_id, expGrant);
        tick();
        checkOutput({tag, "_idle"}, res_valid, 0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;

        // Reset state, with requests present during reset.
        tick();
        checkOutput("rst_valid", res_valid, 0);
        checkOutput("rst_p", res_p, 0);
        checkOutput("rst_id", res_id, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_count", op_count, 0);
        checkOutput("rst_ready", req_ready, 0);
        rst = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        checkOutput("idle_noreq_ready", req_ready, 0);
        tick();
        checkOutput("idle_noreq_busy", busy, 0);

        // Single request from requester 1: 7*7 = 49.
        setOperands(1, 3'd7, 3'd7);
        runOp(4'b0010, 1, 49, "single");
        checkOutput("single_count", op_count, 1);

        // Exhaustive datapath sweep on requester 0.
        doReset();
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                setOperands(0, 3'(a), 3'(b));
                runOp(4'b0001, 0, a * b, "exh");
            end
        end
        checkOutput("exh_count", op_count, 64);

        // Round-robin with all four requesting.
        doReset();
        setOperands(0, 3'd2, 3'd3); rr_prod[0] = 6;
        setOperands(1, 3'd4, 3'd5); rr_prod[1] = 20;
        setOperands(2, 3'd6, 3'd7); rr_prod[2] = 42;
        setOperands(3, 3'd7, 3'd1); rr_prod[3] = 7;
        for (int n = 0; n < 8; n++) begin
            runOp(4'b1111, n % 4, rr_prod[n % 4], "rr");
        end
        checkOutput("rr_count", op_count, 8);

        // Back-pressure on requester 2: 5*3 = 15 held for 10 cycles.
        setOperands(2, 3'd5, 3'd3);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("bp_grant", req_ready, 4'b0100);
        tick();
        tick();
        for (int n = 0; n < 10; n++) begin
            checkOutput("bp_valid", res_valid, 1);
            checkOutput("bp_prod", res_p, 15);
            checkOutput("bp_id", res_id, 2);
            checkOutput("bp_ready", req_ready, 0);
            tick();
        end
        applyStimulus(4'b0000, 1'b1);
        checkOutput("bp_last_valid", res_valid, 1);
        tick();
        checkOutput("bp_accept", res_valid, 0);
        checkOutput("bp_count", op_count, 9);

        // Pointer at 3, only 0 and 1 request: search must wrap to 0.
        runOp(4'b0011, 0, 6, "ptrwrap");

        // Reset while in CALC drops the operation and the pointer.
        applyStimulus(4'b0001, 1'b1);
        checkOutput("midrst_grant", req_ready, 4'b0001);
        tick();
        checkOutput("midrst_calc", busy, 1);
        rst = 1'b1;
        tick();
        checkOutput("midrst_valid", res_valid, 0);
        checkOutput("midrst_p", res_p, 0);
        checkOutput("midrst_id", res_id, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_count", op_count, 0);
        checkOutput("midrst_ready", req_ready, 0);
        rst = 1'b0;
        applyStimulus(4'b0000, 1'b1);
        for (int n = 0; n < 4; n++) begin
            checkOutput("midrst_noresult", res_valid, 0);
            tick();
        end
        runOp(4'b1111, 0, 6, "ptrreset");
        checkOutput("ptrreset_count", op_count, 1);

        // Counter wrap after 256 completions.
        doReset();
        for (int n = 0; n < 255; n++) begin
            runOp(4'b0001, 0, 6, "wrap");
        end
        checkOutput("wrap_255", op_count, 255);
        runOp(4'b0001, 0, 6, "wrap");
        checkOutput("wrap_0", op_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
